keycode_poller: RTL and testbench

- Avalon-MM read master that periodically polls the keycode PIO slave (register at word address 0; readdata[7:0] valid, registered, fixed read latency 1).
- Detects keycode changes and pushes each new value into a small FIFO, exposed as a valid/ready stream to game/video logic.
- Lets hardware consume keypresses without NIOS software involvement.

---
 rtl/keycode_pkg.sv | 18 +
 rtl/keycode_poller_if.sv | 35 +++
 rtl/keycode_fifo.sv | 50 +++++
 rtl/keycode_poller.sv | 124 ++++++++++++
 tb/tb_keycode_poller.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode poller.
package keycode_pkg;

    // Poll transaction phases.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    // Word address of the keycode PIO data register.
    localparam logic [1:0] KEYCODE_ADDR = 2'd0;

    // Default keycode width (readdata[KEY_W-1:0]).
    localparam int KEY_W_DEFAULT = 8;

endpackage

// File: rtl/keycode_poller_if.sv
// Signal bundle between the poller, the Avalon-MM keycode slave and the
// keycode consumer.
//
// Handshakes:
//   Avalon read: avm_read/avm_address are held stable while avm_waitrequest=1;
//     the read is accepted in the cycle where avm_read=1 and avm_waitrequest=0.
//     readdata is valid a fixed READ_LATENCY cycles after acceptance.
//   Key stream: key_data is valid whenever key_valid=1 and stays stable until
//     a transfer; a transfer happens in a cycle with key_valid=1 and key_ready=1.
interface keycode_poller_if import keycode_pkg::*; #(
    parameter int KEY_W = KEY_W_DEFAULT
);
    logic             enable;
    logic [1:0]       avm_address;
    logic             avm_read;
    logic             avm_waitrequest;
    logic [31:0]      avm_readdata;
    logic [KEY_W-1:0] key_data;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] cur_key;
    logic             overflow;

    // Poller side.
    modport master (
        input  enable, avm_waitrequest, avm_readdata, key_ready,
        output avm_address, avm_read, key_data, key_valid, cur_key, overflow
    );

    // Environment side: slave, consumer and control.
    modport slave (
        output enable, avm_waitrequest, avm_readdata, key_ready,
        input  avm_address, avm_read, key_data, key_valid, cur_key, overflow
    );
endinterface

// File: rtl/keycode_fifo.sv
// Synchronous show-ahead FIFO. DEPTH must be a power of two, at least 2.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module keycode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/keycode_poller.sv
// Periodically reads the keycode PIO register over Avalon-MM and queues
// every change of keycode into a small FIFO for hardware consumers.
module keycode_poller import keycode_pkg::*; #(
    parameter int POLL_PERIOD  = 50000,
    parameter int READ_LATENCY = 1,
    parameter int KEY_W        = KEY_W_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic clk,
    input  logic reset,
    keycode_poller_if.master bus,
    output state_e state_o
);
    localparam int              TW           = $clog2(POLL_PERIOD);
    localparam logic [TW-1:0]   TIMER_RELOAD = TW'(POLL_PERIOD - 1);
    localparam logic [1:0]      LAT_RELOAD   = 2'(READ_LATENCY - 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pending_q, pending_d;
    logic [1:0]       lat_q, lat_d;
    logic [KEY_W-1:0] cur_key_q, cur_key_d;
    logic             overflow_q, overflow_d;

    logic             timer_expire;
    logic             capture;
    logic [KEY_W-1:0] sample_key;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_readdata;

    assign timer_expire    = bus.enable && (timer_q == '0);
    assign unused_readdata = ^bus.avm_readdata;

    // FSM, poll timer and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= TIMER_RELOAD;
            pending_q <= 1'b0;
            lat_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            lat_q     <= lat_d;
        end
    end

    // Next state: the timer runs in every state so polls are spaced
    // issue-to-issue; an expiry outside IDLE is remembered as one pending poll.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        lat_d     = lat_q;
        if (bus.enable) timer_d = timer_expire ? TIMER_RELOAD : timer_q - TW'(1);
        if (timer_expire && (state_q != IDLE)) pending_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && (timer_expire || pending_q)) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
                end
            end
            REQ: begin
                if (!bus.avm_waitrequest) begin
                    state_d = WAIT;
                    lat_d   = LAT_RELOAD;
                end
            end
            WAIT: begin
                if (lat_q == 2'd0) state_d = CAPTURE;
                else               lat_d   = lat_q - 2'd1;
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and capture datapath derived from the registered state.
    always_comb begin
        bus.avm_read    = (state_q == REQ);
        bus.avm_address = KEYCODE_ADDR;
        capture         = (state_q == CAPTURE);
        sample_key      = bus.avm_readdata[KEY_W-1:0];
        push            = capture && (sample_key != cur_key_q);
        pop             = bus.key_valid && bus.key_ready;
        cur_key_d       = capture ? sample_key : cur_key_q;
        overflow_d      = overflow_q || (push && fifo_full && !pop);
    end

    // Last sampled keycode and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_key_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cur_key_q  <= cur_key_d;
            overflow_q <= overflow_d;
        end
    end

    keycode_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (sample_key),
        .pop_i   (pop),
        .data_o  (bus.key_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.key_valid = !fifo_empty;
    assign bus.cur_key   = cur_key_q;
    assign bus.overflow  = overflow_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_keycode_poller.sv
// Self-checking bench for keycode_poller: directed steps plus randomized
// polls, checked against a queue-based model of the change-event stream.
module tb_keycode_poller;
  import keycode_pkg::*;

  localparam int POLL_PERIOD  = 8;
  localparam int READ_LATENCY = 1;
  localparam int KEY_W        = 8;
  localparam int FIFO_DEPTH   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  state_e           dut_state;
  logic [KEY_W-1:0] slave_key = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pop_count = 0;

  // Model: expected FIFO contents, last sampled key, sticky overflow.
  logic [KEY_W-1:0] exp_q[$];
  logic [KEY_W-1:0] pop_log[$];
  logic [KEY_W-1:0] m_cur = '0;
  logic             m_ovf = 1'b0;
  int               cap_cnt = 0;

  keycode_poller_if #(.KEY_W(KEY_W)) bus();

  assign bus.avm_readdata = {24'd0, slave_key};

  keycode_poller #(
    .POLL_PERIOD  (POLL_PERIOD),
    .READ_LATENCY (READ_LATENCY),
    .KEY_W        (KEY_W),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dut_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // A read accepted at cycle a is captured at cycle a+READ_LATENCY+1; the
  // captured key is whatever the slave register holds then.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_cur   = '0;
      m_ovf   = 1'b0;
      cap_cnt = 0;
    end else begin
      check("avm_address", 32'(bus.avm_address), 32'(KEYCODE_ADDR));
      check("key_valid", 32'(bus.key_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("key_data", 32'(bus.key_data), 32'(exp_q[0]));
      check("cur_key", 32'(bus.cur_key), 32'(m_cur));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      if (bus.key_valid && bus.key_ready) begin
        pop_count++;
        pop_log.push_back(bus.key_data);
      end
      if (exp_q.size() != 0 && bus.key_ready) void'(exp_q.pop_front());
      if (cap_cnt != 0) begin
        cap_cnt--;
        if (cap_cnt == 0) begin
          if (slave_key != m_cur) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(slave_key);
            else m_ovf = 1'b1;
          end
          m_cur = slave_key;
        end
      end
      if (bus.avm_read && !bus.avm_waitrequest) cap_cnt = READ_LATENCY + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_read(output int c);
    bit ok = 1'b0;
    c = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.avm_read) begin
        ok = 1'b1;
        c = cyc;
      end
    end
    check("read_issue", 32'(ok), 32'd1);
  endtask

  task automatic wait_accept(input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        bus.key_ready = 1'($urandom_range(0, 1));
        bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      if (bus.avm_read && !bus.avm_waitrequest) ok = 1'b1;
    end
    check("read_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_poll(input logic [KEY_W-1:0] v, input bit rnd);
    @(posedge clk); #1;
    slave_key = v;
    wait_accept(rnd);
    repeat (READ_LATENCY + 3) @(negedge clk);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    bus.key_ready = 1'b1;
    for (int i = 0; i < 40 && bus.key_valid; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 32'(bus.key_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [KEY_W-1:0] rv [5];
  logic [KEY_W-1:0] exp3 [4];
  int c0, c1;
  int rd_cnt;

  initial begin
    rv   = '{8'h00, 8'h1C, 8'h04, 8'h2C, 8'h16};
    exp3 = '{8'h04, 8'h07, 8'h16, 8'h1A};
    bus.enable = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.key_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_avm_read", 32'(bus.avm_read), 32'd0);
    check("rst_key_valid", 32'(bus.key_valid), 32'd0);
    check("rst_key_data", 32'(bus.key_data), 32'd0);
    check("rst_cur_key", 32'(bus.cur_key), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_state", 32'(dut_state), 32'(IDLE));

    // Constant key 0x1C: periodic reads, exactly one event.
    @(posedge clk); #1;
    slave_key = 8'h1C;
    bus.key_ready = 1'b1;
    bus.enable = 1'b1;
    wait_read(c0);
    for (int i = 0; i < 3; i++) begin
      wait_read(c1);
      check("poll_interval", 32'(c1 - c0), 32'(POLL_PERIOD));
      c0 = c1;
    end
    repeat (4) @(negedge clk);
    check("t1_cur_key", 32'(bus.cur_key), 32'h1C);
    check("t1_beats", 32'(pop_count), 32'd1);
    check("t1_beat_data", 32'(pop_log[0]), 32'h1C);

    // Waitrequest stall of 5 cycles: request held stable.
    @(posedge clk); #1;
    slave_key = 8'h2A;
    bus.avm_waitrequest = 1'b1;
    wait_read(c0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_read", 32'(bus.avm_read), 32'd1);
    end
    @(posedge clk); #1;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    check("stall_read_last", 32'(bus.avm_read), 32'd1);
    @(negedge clk);
    check("stall_wait_cur", 32'(bus.cur_key), 32'h1C);
    check("stall_wait_read", 32'(bus.avm_read), 32'd0);
    @(negedge clk);
    check("stall_capture_cur", 32'(bus.cur_key), 32'h1C);
    @(negedge clk);
    check("stall_after_cur", 32'(bus.cur_key), 32'h2A);

    // Full FIFO with pop and changed capture in the same cycle.
    @(posedge clk); #1;
    bus.key_ready = 1'b0;
    do_poll(8'h31, 1'b0);
    do_poll(8'h32, 1'b0);
    do_poll(8'h33, 1'b0);
    do_poll(8'h34, 1'b0);
    check("full_valid", 32'(bus.key_valid), 32'd1);
    @(posedge clk); #1;
    slave_key = 8'h35;
    pop_log.delete();
    wait_accept(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.key_ready = 1'b1;
    @(posedge clk); #1;
    bus.key_ready = 1'b0;
    check("pp_pop_count", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() == 1) check("pp_pop_data", 32'(pop_log[0]), 32'h31);
    repeat (2) @(negedge clk);
    check("pp_overflow", 32'(bus.overflow), 32'd0);
    pop_log.delete();
    drain();
    check("pp_drain_count", 32'(pop_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      check("pp_drain_data", 32'(pop_log[i]), 32'(8'h32 + i));

    // Overflow: five changes into a four-entry FIFO with no consumer.
    @(posedge clk); #1;
    bus.key_ready = 1'b0;
    do_poll(8'h04, 1'b0);
    do_poll(8'h07, 1'b0);
    do_poll(8'h16, 1'b0);
    do_poll(8'h1A, 1'b0);
    do_poll(8'h2C, 1'b0);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_cur_key", 32'(bus.cur_key), 32'h2C);
    pop_log.delete();
    drain();
    check("ovf_drain_count", 32'(pop_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      check("ovf_drain_data", 32'(pop_log[i]), 32'(exp3[i]));
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Randomized polls with random consumer and stalls.
    for (int i = 0; i < 16; i++) do_poll(rv[$urandom_range(0, 4)], 1'b1);
    @(posedge clk); #1;
    bus.avm_waitrequest = 1'b0;
    drain();

    // Enable dropped mid-request: read completes, then polling parks.
    @(posedge clk); #1;
    slave_key = 8'h3D;
    pop_log.delete();
    bus.avm_waitrequest = 1'b1;
    wait_read(c0);
    @(posedge clk); #1;
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en_hold_read", 32'(bus.avm_read), 32'd1);
    end
    @(posedge clk); #1;
    bus.avm_waitrequest = 1'b0;
    repeat (READ_LATENCY + 4) @(negedge clk);
    rd_cnt = 0;
    for (int i = 0; i < 3 * POLL_PERIOD; i++) begin
      @(negedge clk);
      if (bus.avm_read) rd_cnt++;
    end
    check("en_off_reads", 32'(rd_cnt), 32'd0);
    check("en_cur_key", 32'(bus.cur_key), 32'h3D);
    check("en_events", 32'(pop_log.size()), 32'd1);
    @(posedge clk); #1;
    bus.enable = 1'b1;
    wait_read(c0);

    // Reset pulsed while waiting for read data.
    @(posedge clk); #1;
    bus.key_ready = 1'b0;
    do_poll(8'h55, 1'b0);
    @(posedge clk); #1;
    slave_key = 8'h66;
    bus.avm_waitrequest = 1'b1;
    wait_read(c0);
    @(posedge clk); #1;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_state", 32'(dut_state), 32'(WAIT));
    @(posedge clk); #1;
    reset = 1'b0;
    slave_key = 8'h00;
    bus.key_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_read", 32'(bus.avm_read), 32'd0);
    check("rst_mid_valid", 32'(bus.key_valid), 32'd0);
    check("rst_mid_cur", 32'(bus.cur_key), 32'd0);
    check("rst_mid_ovf", 32'(bus.overflow), 32'd0);
    pop_log.delete();
    do_poll(8'h00, 1'b0);
    check("rst_zero_valid", 32'(bus.key_valid), 32'd0);
    check("rst_zero_cur", 32'(bus.cur_key), 32'd0);
    check("rst_zero_events", 32'(pop_log.size()), 32'd0);

    // Final report.
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
